// File: rtl/io_stim_pkg.sv
// io_stim_pkg: shared step encoding, FSM states and default widths for the stimulus sequencer
package io_stim_pkg;
  localparam int SW_W_DEF  = 10;
  localparam int N_BTN_DEF = 2;
  localparam int LED_W_DEF = 10;
  localparam int DEPTH_DEF = 16;
  localparam int DUR_W_DEF = 16;
  typedef enum logic [1:0] {OP_HOLD, OP_WAIT_LED, OP_END, OP_RSVD} step_op_t;
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_WAIT, S_DONE, S_ERR} state_t;
  typedef struct packed {
    step_op_t               op;
    logic [SW_W_DEF-1:0]    sw;
    logic [N_BTN_DEF-1:0]   btn;
    logic [DUR_W_DEF-1:0]   dur;
    logic [LED_W_DEF-1:0]   led;
  } step_t;
  localparam int STEP_W_DEF = $bits(step_t);
endpackage

// File: rtl/io_stim_sequencer_mem.sv
// stim_step_mem: step register array, one synchronous write port and one combinational read port
module stim_step_mem
  import io_stim_pkg::*;
#(
  parameter int W     = STEP_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/io_stim_sequencer.sv
// io_stim_sequencer: replays programmed switch/button steps into the SLC-3 front panel
module io_stim_sequencer
  import io_stim_pkg::*;
#(
  parameter int SW_W  = SW_W_DEF,
  parameter int N_BTN = N_BTN_DEF,
  parameter int LED_W = LED_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [1:0]               prog_op,
  input  logic [SW_W-1:0]          prog_sw,
  input  logic [N_BTN-1:0]         prog_btn,
  input  logic [DUR_W-1:0]         prog_dur,
  input  logic [LED_W-1:0]         prog_led,
  input  logic                     start,
  input  logic [LED_W-1:0]         led_i,
  output logic [SW_W-1:0]          SW,
  output logic [N_BTN-1:0]         btn_n,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH)-1:0] step_idx
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = 2 + SW_W + N_BTN + DUR_W + LED_W;
  state_t             state, n_state;
  logic [DUR_W-1:0]   cnt, n_cnt;
  logic [LED_W-1:0]   exp_led, n_exp_led;
  logic [SW_W-1:0]    n_sw;
  logic [N_BTN-1:0]   n_btn_n;
  logic               n_done, n_terr, adv, disp;
  logic [AW-1:0]      n_idx, raddr;
  logic [W-1:0]       rd;
  logic [1:0]         r_op_bits;
  step_op_t           r_op;
  logic [SW_W-1:0]    r_sw;
  logic [N_BTN-1:0]   r_btn;
  logic [DUR_W-1:0]   r_dur;
  logic [LED_W-1:0]   r_led;
  assign busy  = state == S_HOLD || state == S_WAIT;
  // Only one entry is ever fetched per edge: entry 0 on start, otherwise the successor
  assign raddr = busy ? step_idx + AW'(1) : '0;
  assign {r_op_bits, r_sw, r_btn, r_dur, r_led} = rd;
  assign r_op = step_op_t'(r_op_bits);
  stim_step_mem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (Clk),
    .we    (prog_we && !busy),
    .waddr (prog_addr),
    .wdata ({prog_op, prog_sw, prog_btn, prog_dur, prog_led}),
    .raddr (raddr),
    .rdata (rd)
  );
  always_comb begin
    n_state   = state;
    n_cnt     = cnt;
    n_exp_led = exp_led;
    n_sw      = SW;
    n_btn_n   = btn_n;
    n_done    = done;
    n_terr    = timeout_err;
    n_idx     = step_idx;
    adv       = 1'b0;
    disp      = 1'b0;
    if (!busy && start) begin
      n_done = 1'b0;
      n_terr = 1'b0;
      n_idx  = '0;
      disp   = 1'b1;
    end else if (state == S_HOLD) begin
      adv   = cnt == '0;
      n_cnt = adv ? cnt : cnt - DUR_W'(1);
    end else if (state == S_WAIT) begin
      adv = led_i == exp_led;
      if (!adv && cnt == '0) begin
        n_btn_n = '1;
        n_terr  = 1'b1;
        n_state = S_ERR;
      end else if (!adv) n_cnt = cnt - DUR_W'(1);
    end
    // Running off the end of the list behaves like an END entry without moving the index
    if (adv && step_idx == AW'(DEPTH - 1)) begin
      n_btn_n = '1;
      n_done  = 1'b1;
      n_state = S_DONE;
    end else if (adv) begin
      n_idx = step_idx + AW'(1);
      disp  = 1'b1;
    end
    if (disp && (r_op == OP_HOLD || r_op == OP_WAIT_LED)) begin
      n_sw      = r_sw;
      n_btn_n   = ~r_btn;
      n_exp_led = r_led;
      n_state   = r_op == OP_HOLD ? S_HOLD : S_WAIT;
      n_cnt     = r_op == OP_WAIT_LED ? r_dur : (r_dur == '0 ? '0 : r_dur - DUR_W'(1));
    end else if (disp) begin
      n_btn_n = '1;
      n_done  = 1'b1;
      n_state = S_DONE;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      exp_led     <= '0;
      SW          <= '0;
      btn_n       <= '1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      step_idx    <= '0;
    end else begin
      state       <= n_state;
      cnt         <= n_cnt;
      exp_led     <= n_exp_led;
      SW          <= n_sw;
      btn_n       <= n_btn_n;
      done        <= n_done;
      timeout_err <= n_terr;
      step_idx    <= n_idx;
    end
  end
endmodule

// File: tb/tb_io_stim_sequencer.sv
// tb_io_stim_sequencer: randomized and directed playback checked against a step-list reference model
module tb_io_stim_sequencer;
  localparam int DEPTH = 16;
  logic        Clk = 1'b0, Reset = 1'b1, prog_we = 1'b0, start = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [1:0]  prog_op = '0, prog_btn = '0;
  logic [9:0]  prog_sw = '0, prog_led = '0, led_i = '0;
  logic [15:0] prog_dur = '0;
  logic [9:0]  SW;
  logic [1:0]  btn_n;
  logic        busy, done, timeout_err;
  logic [3:0]  step_idx;
  logic [18:0] obs;
  int checks = 0, errors = 0;
  logic [1:0] m_op [DEPTH];
  logic [9:0] m_swv [DEPTH], m_led [DEPTH];
  logic [1:0] m_btn [DEPTH];
  int         m_dur [DEPTH], m_match [DEPTH];
  logic [9:0] m_sw = '0;
  typedef struct {logic [18:0] o; logic [9:0] led;} rec_t;
  rec_t        q[$];
  logic [18:0] fin_o;
  io_stim_sequencer dut (
    .Clk(Clk), .Reset(Reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op),
    .prog_sw(prog_sw), .prog_btn(prog_btn), .prog_dur(prog_dur), .prog_led(prog_led),
    .start(start), .led_i(led_i), .SW(SW), .btn_n(btn_n), .busy(busy), .done(done),
    .timeout_err(timeout_err), .step_idx(step_idx)
  );
  always #5 Clk = ~Clk;
  assign obs = {SW, btn_n, busy, done, timeout_err, step_idx};
  function automatic logic [18:0] pk(logic [9:0] sw, logic [1:0] bn, logic b, logic d, logic t, logic [3:0] ix);
    return {sw, bn, b, d, t, ix};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic prog(input int i, input logic [1:0] op, input logic [9:0] sw, input logic [1:0] btn,
                      input int dur, input logic [9:0] led, input int match);
    prog_we = 1'b1; prog_addr = 4'(i); prog_op = op; prog_sw = sw; prog_btn = btn;
    prog_dur = 16'(dur); prog_led = led;
    m_op[i] = op; m_swv[i] = sw; m_btn[i] = btn; m_dur[i] = dur; m_led[i] = led; m_match[i] = match;
    @(negedge Clk);
    prog_we = 1'b0;
  endtask
  // Walks the step list: per-cycle expected outputs plus the LED value to present in that cycle
  task automatic build();
    int i = 0;
    q.delete();
    while (1) begin
      if (i == DEPTH) begin
        fin_o = pk(m_sw, 2'b11, 0, 1, 0, 4'(DEPTH - 1));
        break;
      end
      if (m_op[i] >= 2) begin
        fin_o = pk(m_sw, 2'b11, 0, 1, 0, 4'(i));
        break;
      end
      m_sw = m_swv[i];
      if (m_op[i] == 0) begin
        for (int j = 0; j < (m_dur[i] == 0 ? 1 : m_dur[i]); j++)
          q.push_back('{pk(m_sw, ~m_btn[i], 1, 0, 0, 4'(i)), 10'($urandom)});
      end else begin
        for (int j = 0; j <= m_dur[i] && j <= m_match[i]; j++)
          q.push_back('{pk(m_sw, ~m_btn[i], 1, 0, 0, 4'(i)),
                        j == m_match[i] ? m_led[i] : m_led[i] ^ 10'($urandom_range(1, 1023))});
        if (m_match[i] > m_dur[i]) begin
          fin_o = pk(m_sw, 2'b11, 0, 0, 1, 4'(i));
          break;
        end
      end
      i++;
    end
  endtask
  task automatic run(input string tag);
    build();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    foreach (q[k]) begin
      chk({tag, "_step"}, 32'(obs), 32'(q[k].o));
      led_i = q[k].led;
      @(negedge Clk);
    end
    chk({tag, "_final"}, 32'(obs), 32'(fin_o));
    @(negedge Clk);
    chk({tag, "_hold"}, 32'(obs), 32'(fin_o));
  endtask
  initial begin
    repeat (2) @(negedge Clk);
    chk("reset", 32'(obs), 32'(pk(0, 2'b11, 0, 0, 0, 0)));
    Reset = 1'b0;
    @(negedge Clk);
    prog(0, 2'd0, 10'h031, 2'b00, 2, 10'h0, 0);
    prog(1, 2'd0, 10'h031, 2'b01, 3, 10'h0, 0);
    prog(2, 2'd0, 10'h031, 2'b00, 1, 10'h0, 0);
    prog(3, 2'd2, 10'h000, 2'b00, 0, 10'h0, 0);
    run("press");
    prog(0, 2'd1, 10'h05A, 2'b10, 100, 10'h001, 40);
    prog(1, 2'd2, 10'h000, 2'b00, 0, 10'h0, 0);
    run("wait_match");
    m_match[0] = 1000;
    run("wait_timeout");
    m_match[0] = 40;
    run("wait_restart");
    for (int i = 0; i < DEPTH; i++) prog(i, 2'd0, 10'($urandom), 2'($urandom), 0, 10'h0, 0);
    run("no_wrap");
    prog(0, 2'd0, 10'h2AA, 2'b10, 10, 10'h0, 0);
    prog(1, 2'd2, 10'h000, 2'b00, 0, 10'h0, 0);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    chk("mid_btn", 32'(btn_n), 32'(2'b01));
    prog_we = 1'b1; prog_addr = 4'd0; prog_op = 2'd2; prog_sw = 10'h155;
    @(negedge Clk);
    prog_we = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    chk("reset_mid", 32'(obs), 32'(pk(0, 2'b11, 0, 0, 0, 0)));
    Reset = 1'b0;
    m_sw = '0;
    run("replay");
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int r, d;
        r = $urandom_range(0, 19);
        d = $urandom_range(0, 5);
        prog(i, r < 11 ? 2'd0 : r < 17 ? 2'd1 : r < 19 ? 2'd2 : 2'd3, 10'($urandom), 2'($urandom),
             d, 10'($urandom), $urandom_range(0, d + 2));
      end
      run("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
